// File: rtl/count_checker.sv
// count_checker: tracks samples of a 4-bit up-counter and flags sequence breaks.
// Optional error counter enabled by defining CHECKER_ERRCNT_EN; without it
// err_count is tied to zero and no counter register exists.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   UNLOCKED  | no history; next valid sample seeds expected
//   ACQUIRE   | expected seeded; waiting for one matching sample to lock
//   LOCKED    | tracking a correct sequence; a break pulses mismatch
module count_checker (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [3:0] count_in,
    output logic       locked,
    output logic       mismatch,
    output logic       wrap,
    output logic [3:0] expected,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] expected_q, expected_d;
    logic       locked_q, locked_d;
    logic       mismatch_q, mismatch_d;
    logic       wrap_q, wrap_d;

    logic [3:0] count_inc;
    logic [3:0] expected_inc;
    logic       sample_match;

    // 4-bit increments wrap naturally; the carry out is simply dropped
    assign count_inc    = count_in + 4'd1;
    assign expected_inc = expected_q + 4'd1;
    assign sample_match = (count_in == expected_q);

    // Next-state and next-output decode; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    expected_d = count_inc;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (sample_match) begin
                        expected_d = expected_inc;
                        state_d    = LOCKED;
                    end else begin
                        expected_d = count_inc;
                    end
                end
                LOCKED: begin
                    if (sample_match) begin
                        expected_d = expected_inc;
                        // a match on 0 while locked means the previous accepted value was 15
                        wrap_d     = (count_in == 4'd0);
                    end else begin
                        mismatch_d = 1'b1;
                        expected_d = count_inc;
                        state_d    = ACQUIRE;
                    end
                end
                default: begin
                    state_d    = UNLOCKED;
                    expected_d = 4'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            expected_q <= 4'd0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
        end
    end

    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign wrap     = wrap_q;
    assign expected = expected_q;

`ifdef CHECKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of mismatch pulses
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Testbench for count_checker: reference model feeds a scoreboard queue, plus
// directed checks of the documented scenarios. Honours CHECKER_ERRCNT_EN.
module tb_count_checker;

    logic       clock;
    logic       reset;
    logic       sample_valid;
    logic [3:0] count_in;
    logic       locked;
    logic       mismatch;
    logic       wrap;
    logic [3:0] expected;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    count_checker dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .locked       (locked),
        .mismatch     (mismatch),
        .wrap         (wrap),
        .expected     (expected),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       locked;
        logic       mismatch;
        logic       wrap;
        logic [3:0] expected;
        logic [7:0] err;
    } exp_t;

    exp_t sb[$];

    // reference model: 0 = unlocked, 1 = acquiring, 2 = locked
    int         m_mode = 0;
    logic [3:0] m_exp  = 4'd0;
    logic [3:0] m_last = 4'd0;
    int         m_err  = 0;
    logic       m_mm   = 1'b0;
    logic       m_wrap = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, req);
        end
    endtask

    task automatic model(input logic v, input logic [3:0] d, input logic r);
        m_mm   = 1'b0;
        m_wrap = 1'b0;
        if (r) begin
            m_mode = 0;
            m_exp  = 4'd0;
            m_err  = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                m_exp  = d + 4'd1;
                m_mode = 1;
            end else if (d == m_exp) begin
                if (m_mode == 2 && d == 4'd0 && m_last == 4'd15) m_wrap = 1'b1;
                m_exp  = m_exp + 4'd1;
                m_mode = 2;
            end else begin
                if (m_mode == 2) begin
                    m_mm = 1'b1;
`ifdef CHECKER_ERRCNT_EN
                    if (m_err < 255) m_err++;
`endif
                end
                m_exp  = d + 4'd1;
                m_mode = 1;
            end
            m_last = d;
        end
    endtask

    // drive one cycle, push the model's prediction, then pop and compare
    task automatic step(input logic v, input logic [3:0] d, input logic r);
        exp_t e;
        exp_t got;
        @(negedge clock);
        sample_valid = v;
        count_in     = d;
        reset        = r;
        model(v, d, r);
        e.locked   = (m_mode == 2);
        e.mismatch = m_mm;
        e.wrap     = m_wrap;
        e.expected = m_exp;
        e.err      = 8'(m_err);
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk("sb_locked",   {7'd0, locked},   {7'd0, got.locked});
        chk("sb_mismatch", {7'd0, mismatch}, {7'd0, got.mismatch});
        chk("sb_wrap",     {7'd0, wrap},     {7'd0, got.wrap});
        chk("sb_expected", {4'd0, expected}, {4'd0, got.expected});
        chk("sb_err",      err_count,        got.err);
        chk("sb_excl",     {7'd0, (mismatch & wrap)}, 8'd0);
    endtask

    int wrap_seen;
    int mm_seen;
    logic [3:0] v4;

    initial begin
        sample_valid = 1'b0;
        count_in     = 4'd0;
        reset        = 1'b1;

        // reset state
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd9, 1'b1);
        chk("rst_locked",   {7'd0, locked},   8'd0);
        chk("rst_expected", {4'd0, expected}, 8'd0);
        chk("rst_err",      err_count,        8'd0);

        // samples 3,4,5,6: locks the cycle after 4, expected 7
        mm_seen = 0;
        step(1'b1, 4'd3, 1'b0);
        chk("acq_locked", {7'd0, locked}, 8'd0);
        step(1'b1, 4'd4, 1'b0);
        chk("lock_rise", {7'd0, locked}, 8'd1);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        chk("seq_expected", {4'd0, expected}, 8'd7);
        chk("seq_locked",   {7'd0, locked},   8'd1);

        // run to 13, then 14,15,0,1: exactly one wrap, one cycle after 0
        for (int i = 7; i <= 13; i++) step(1'b1, 4'(i), 1'b0);
        wrap_seen = 0;
        step(1'b1, 4'd14, 1'b0); wrap_seen += int'(wrap);
        step(1'b1, 4'd15, 1'b0); wrap_seen += int'(wrap);
        step(1'b1, 4'd0,  1'b0);
        chk("wrap_pulse", {7'd0, wrap}, 8'd1);
        wrap_seen += int'(wrap);
        step(1'b1, 4'd1,  1'b0); wrap_seen += int'(wrap);
        chk("wrap_once", 8'(wrap_seen), 8'd1);
        chk("wrap_expected", {4'd0, expected}, 8'd2);

        // expected 5, sample 9 -> mismatch, unlock, expected 10
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd4, 1'b0);
        chk("pre_mm_expected", {4'd0, expected}, 8'd5);
        step(1'b1, 4'd9, 1'b0);
        chk("mm_pulse",    {7'd0, mismatch}, 8'd1);
        chk("mm_locked",   {7'd0, locked},   8'd0);
        chk("mm_expected", {4'd0, expected}, 8'd10);
`ifdef CHECKER_ERRCNT_EN
        chk("mm_err", err_count, 8'd1);
`else
        chk("mm_err", err_count, 8'd0);
`endif
        step(1'b1, 4'd10, 1'b0);
        chk("relock",      {7'd0, locked},   8'd1);
        chk("mm_cleared",  {7'd0, mismatch}, 8'd0);

        // 10 idle cycles with random count_in, then matching sample
        for (int i = 0; i < 10; i++) begin
            v4 = 4'($urandom_range(0, 15));
            step(1'b0, v4, 1'b0);
            mm_seen += int'(mismatch);
        end
        chk("idle_expected", {4'd0, expected}, 8'd11);
        step(1'b1, 4'd11, 1'b0);
        chk("idle_no_mm", 8'(mm_seen + int'(mismatch)), 8'd0);
        chk("idle_locked", {7'd0, locked}, 8'd1);

        // reset with a mismatching sample while locked
        step(1'b1, 4'd3, 1'b1);
        chk("rstpri_locked",   {7'd0, locked},   8'd0);
        chk("rstpri_mm",       {7'd0, mismatch}, 8'd0);
        chk("rstpri_expected", {4'd0, expected}, 8'd0);
        chk("rstpri_err",      err_count,        8'd0);
        step(1'b1, 4'd7, 1'b0);
        chk("post_rst_acq",  {7'd0, locked},   8'd0);
        chk("post_rst_exp",  {4'd0, expected}, 8'd8);

        // 300 forced mismatches: lock on expected, then break by +2
        for (int i = 0; i < 300; i++) begin
            step(1'b1, m_exp, 1'b0);
            step(1'b1, m_exp + 4'd2, 1'b0);
        end
`ifdef CHECKER_ERRCNT_EN
        chk("err_sat", err_count, 8'd255);
`else
        chk("err_zero", err_count, 8'd0);
`endif
        step(1'b1, m_exp, 1'b0);
        step(1'b1, m_exp + 4'd2, 1'b0);
`ifdef CHECKER_ERRCNT_EN
        chk("err_hold", err_count, 8'd255);
`else
        chk("err_hold", err_count, 8'd0);
`endif
        step(1'b0, 4'd0, 1'b1);
        chk("err_clear", err_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset; all state changes on the rising edge of clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 sample_valid  input  1  qualifies count_in; low means no sample this cycle.
REQ-005 count_in  input  4  sampled counter value from the 4-bit up-counter under observation.
REQ-006 locked  output  1  high while the checker is tracking a correct sequence.
REQ-007 mismatch  output  1  one-cycle pulse: a locked sample differed from expected.
REQ-008 wrap  output  1  one-cycle pulse: a locked sample of 0 was accepted after 15.
REQ-009 expected  output  4  next value the checker requires.
REQ-010 err_count  output  8  count of mismatch pulses (see Configuration).

Function
REQ-011 States SHALL be UNLOCKED, ACQUIRE and LOCKED; locked = 1 only in LOCKED.
REQ-012 All outputs SHALL be registered; a response appears one cycle after the sampling edge.
REQ-013 Cycles with sample_valid = 0 SHALL change nothing except clearing the mismatch and wrap pulses; count_in is ignored.
REQ-014 UNLOCKED, valid sample: expected <= count_in + 1 (mod 16), go to ACQUIRE.
REQ-015 ACQUIRE, valid sample equal to expected: expected <= expected + 1 (mod 16), go to LOCKED; no mismatch pulse.
REQ-016 ACQUIRE, valid sample not equal to expected: expected <= count_in + 1 (mod 16), stay in ACQUIRE; no mismatch pulse.
REQ-017 LOCKED, valid sample equal to expected: expected <= expected + 1 (mod 16), stay in LOCKED.
REQ-018 LOCKED, valid sample not equal to expected: mismatch = 1 for one cycle, expected <= count_in + 1 (mod 16), go to ACQUIRE.
REQ-019 wrap SHALL pulse only in LOCKED, when an accepted sample equals 0 and the previous accepted value was 15.
REQ-020 All arithmetic on expected SHALL be 4-bit modulo 16: 15 + 1 = 0, with no carry out.
REQ-021 mismatch and wrap SHALL never assert in the same cycle.

Reset
REQ-022 Reset SHALL take priority over sample_valid in the same cycle.
REQ-023 On reset: state UNLOCKED, locked = 0, mismatch = 0, wrap = 0, expected = 0, err_count = 0.
REQ-024 Reset asserted while LOCKED SHALL discard tracking; the first valid sample after release is treated as in UNLOCKED.

Configuration
REQ-025 Macro CHECKER_ERRCNT_EN SHALL control the error counter.
REQ-026 With the macro defined: err_count increments by 1 on each mismatch pulse, saturates at 255 and clears only on reset.
REQ-027 Without the macro: err_count is constant 0 and no counter register exists; all other behaviour is identical.

Verification
REQ-028 Reset, then valid samples 3,4,5,6 -> locked rises the cycle after sample 4; expected = 7; mismatch never asserts.
REQ-029 Locked on samples 14,15,0,1 -> wrap pulses exactly once, one cycle after sample 0; expected = 2 at the end.
REQ-030 Locked with expected = 5, then sample 9 -> mismatch pulses one cycle, locked = 0, expected = 10, err_count = 1 (macro defined); sample 10 -> locked = 1 again.
REQ-031 Locked, then sample_valid = 0 for 10 cycles with count_in toggling randomly, then sample equal to expected -> no mismatch, locked stays 1.
REQ-032 Reset asserted together with a valid mismatching sample while locked -> all outputs 0 next cycle and no mismatch pulse.
REQ-033 With macro defined, 300 forced mismatches -> err_count = 255; without the macro -> err_count = 0 throughout.
